// File: rtl/tx_state_store.sv
// Per-flow TCP transmit-state store: two independent registered read ports and one
// fixed-priority write port. Define TX_STATE_STORE_WR_FWD_EN for write-first forwarding.
package tcp_pkg;
    localparam int FLOWID_W = 6;

    typedef struct packed {
        logic [31:0] snd_una;
        logic [31:0] snd_nxt;
        logic [15:0] snd_wnd;
    } tx_state_struct;
endpackage

module tx_state_store
    import tcp_pkg::*;
#(
    parameter int DEPTH = 2 ** FLOWID_W
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                new_flow_val,
    input  logic [FLOWID_W-1:0] new_flow_flowid,
    input  tx_state_struct      new_flow_data,
    output logic                new_flow_rdy,

    input  logic                send_pipe_tx_state_rd_req_val,
    input  logic [FLOWID_W-1:0] send_pipe_tx_state_rd_req_flowid,
    output logic                tx_state_send_pipe_rd_req_rdy,

    output logic                tx_state_send_pipe_rd_resp_val,
    output tx_state_struct      tx_state_send_pipe_rd_resp_data,
    input  logic                send_pipe_tx_state_rd_resp_rdy,

    input  logic                send_pipe_tx_state_wr_req_val,
    input  logic [FLOWID_W-1:0] send_pipe_tx_state_wr_req_flowid,
    input  tx_state_struct      send_pipe_tx_state_wr_req_data,
    output logic                tx_state_send_pipe_wr_req_rdy,

    input  logic                rx_pipe_tx_state_rd_req_val,
    input  logic [FLOWID_W-1:0] rx_pipe_tx_state_rd_req_flowid,
    output logic                tx_state_rx_pipe_rd_req_rdy,

    output logic                tx_state_rx_pipe_rd_resp_val,
    output tx_state_struct      tx_state_rx_pipe_rd_resp_data,
    input  logic                rx_pipe_tx_state_rd_resp_rdy,

    input  logic                rx_pipe_tx_state_wr_req_val,
    input  logic [FLOWID_W-1:0] rx_pipe_tx_state_wr_req_flowid,
    input  tx_state_struct      rx_pipe_tx_state_wr_req_data,
    output logic                tx_state_rx_pipe_wr_req_rdy
);

    tx_state_struct      mem_r [DEPTH];

    logic                wr_en_s;
    logic [FLOWID_W-1:0] wr_addr_s;
    tx_state_struct      wr_data_s;

    logic                send_rd_acc_s;
    logic                rx_rd_acc_s;
    tx_state_struct      send_rd_data_s;
    tx_state_struct      rx_rd_data_s;

    logic                send_resp_val_r;
    tx_state_struct      send_resp_data_r;
    logic                rx_resp_val_r;
    tx_state_struct      rx_resp_data_r;

    assign new_flow_rdy                  = 1'b1;
    assign tx_state_rx_pipe_wr_req_rdy   = !new_flow_val;
    assign tx_state_send_pipe_wr_req_rdy = !new_flow_val && !rx_pipe_tx_state_wr_req_val;

    assign tx_state_send_pipe_rd_req_rdy = !send_resp_val_r || send_pipe_tx_state_rd_resp_rdy;
    assign tx_state_rx_pipe_rd_req_rdy   = !rx_resp_val_r || rx_pipe_tx_state_rd_resp_rdy;

    assign send_rd_acc_s = send_pipe_tx_state_rd_req_val && tx_state_send_pipe_rd_req_rdy;
    assign rx_rd_acc_s   = rx_pipe_tx_state_rd_req_val && tx_state_rx_pipe_rd_req_rdy;

    assign tx_state_send_pipe_rd_resp_val  = send_resp_val_r;
    assign tx_state_send_pipe_rd_resp_data = send_resp_data_r;
    assign tx_state_rx_pipe_rd_resp_val    = rx_resp_val_r;
    assign tx_state_rx_pipe_rd_resp_data   = rx_resp_data_r;

    // Fixed-priority write select: new_flow, then rx pipe, then send pipe.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = '0;
        wr_data_s = '0;
        if (new_flow_val) begin
            wr_en_s   = 1'b1;
            wr_addr_s = new_flow_flowid;
            wr_data_s = new_flow_data;
        end else if (rx_pipe_tx_state_wr_req_val) begin
            wr_en_s   = 1'b1;
            wr_addr_s = rx_pipe_tx_state_wr_req_flowid;
            wr_data_s = rx_pipe_tx_state_wr_req_data;
        end else if (send_pipe_tx_state_wr_req_val) begin
            wr_en_s   = 1'b1;
            wr_addr_s = send_pipe_tx_state_wr_req_flowid;
            wr_data_s = send_pipe_tx_state_wr_req_data;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Read data source per port; forwarding build returns the same-cycle write.
    always_comb begin
        send_rd_data_s = mem_r[send_pipe_tx_state_rd_req_flowid];
        rx_rd_data_s   = mem_r[rx_pipe_tx_state_rd_req_flowid];
`ifdef TX_STATE_STORE_WR_FWD_EN
        if (wr_en_s && (wr_addr_s == send_pipe_tx_state_rd_req_flowid)) begin
            send_rd_data_s = wr_data_s;
        end else begin
            send_rd_data_s = mem_r[send_pipe_tx_state_rd_req_flowid];
        end
        if (wr_en_s && (wr_addr_s == rx_pipe_tx_state_rd_req_flowid)) begin
            rx_rd_data_s = wr_data_s;
        end else begin
            rx_rd_data_s = mem_r[rx_pipe_tx_state_rd_req_flowid];
        end
`endif
    end

    // Storage array; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Send-pipe response register, held until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            send_resp_val_r  <= 1'b0;
            send_resp_data_r <= '0;
        end else if (send_rd_acc_s) begin
            send_resp_val_r  <= 1'b1;
            send_resp_data_r <= send_rd_data_s;
        end else if (send_pipe_tx_state_rd_resp_rdy) begin
            send_resp_val_r  <= 1'b0;
        end
    end

    // RX-pipe response register, held until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_resp_val_r  <= 1'b0;
            rx_resp_data_r <= '0;
        end else if (rx_rd_acc_s) begin
            rx_resp_val_r  <= 1'b1;
            rx_resp_data_r <= rx_rd_data_s;
        end else if (rx_pipe_tx_state_rd_resp_rdy) begin
            rx_resp_val_r  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_state_store.sv
// Directed self-checking bench for tx_state_store; follows TX_STATE_STORE_WR_FWD_EN if defined.
module tb_tx_state_store;
    import tcp_pkg::*;

    logic                clk;
    logic                rst;
    logic                new_flow_val;
    logic [FLOWID_W-1:0] new_flow_flowid;
    tx_state_struct      new_flow_data;
    logic                new_flow_rdy;
    logic                s_rd_val;
    logic [FLOWID_W-1:0] s_rd_fid;
    logic                s_rd_rdy;
    logic                s_resp_val;
    tx_state_struct      s_resp_data;
    logic                s_resp_rdy;
    logic                s_wr_val;
    logic [FLOWID_W-1:0] s_wr_fid;
    tx_state_struct      s_wr_data;
    logic                s_wr_rdy;
    logic                r_rd_val;
    logic [FLOWID_W-1:0] r_rd_fid;
    logic                r_rd_rdy;
    logic                r_resp_val;
    tx_state_struct      r_resp_data;
    logic                r_resp_rdy;
    logic                r_wr_val;
    logic [FLOWID_W-1:0] r_wr_fid;
    tx_state_struct      r_wr_data;
    logic                r_wr_rdy;

    int tests_run;
    int tests_failed;

    tx_state_store dut (
        .clk                              (clk),
        .rst                              (rst),
        .new_flow_val                     (new_flow_val),
        .new_flow_flowid                  (new_flow_flowid),
        .new_flow_data                    (new_flow_data),
        .new_flow_rdy                     (new_flow_rdy),
        .send_pipe_tx_state_rd_req_val    (s_rd_val),
        .send_pipe_tx_state_rd_req_flowid (s_rd_fid),
        .tx_state_send_pipe_rd_req_rdy    (s_rd_rdy),
        .tx_state_send_pipe_rd_resp_val   (s_resp_val),
        .tx_state_send_pipe_rd_resp_data  (s_resp_data),
        .send_pipe_tx_state_rd_resp_rdy   (s_resp_rdy),
        .send_pipe_tx_state_wr_req_val    (s_wr_val),
        .send_pipe_tx_state_wr_req_flowid (s_wr_fid),
        .send_pipe_tx_state_wr_req_data   (s_wr_data),
        .tx_state_send_pipe_wr_req_rdy    (s_wr_rdy),
        .rx_pipe_tx_state_rd_req_val      (r_rd_val),
        .rx_pipe_tx_state_rd_req_flowid   (r_rd_fid),
        .tx_state_rx_pipe_rd_req_rdy      (r_rd_rdy),
        .tx_state_rx_pipe_rd_resp_val     (r_resp_val),
        .tx_state_rx_pipe_rd_resp_data    (r_resp_data),
        .rx_pipe_tx_state_rd_resp_rdy     (r_resp_rdy),
        .rx_pipe_tx_state_wr_req_val      (r_wr_val),
        .rx_pipe_tx_state_wr_req_flowid   (r_wr_fid),
        .rx_pipe_tx_state_wr_req_data     (r_wr_data),
        .tx_state_rx_pipe_wr_req_rdy      (r_wr_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic tx_state_struct mk(input int n);
        tx_state_struct v;
        v.snd_una = 32'h1000_0000 + n;
        v.snd_nxt = 32'h2000_0000 + (n * 3);
        v.snd_wnd = 16'(n * 7 + 1);
        return v;
    endfunction

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr;
        new_flow_val = 1'b0;
        s_rd_val     = 1'b0;
        s_wr_val     = 1'b0;
        r_rd_val     = 1'b0;
        r_wr_val     = 1'b0;
        s_resp_rdy   = 1'b1;
        r_resp_rdy   = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clr();
        step();
        step();
        #1;
        tests_run++;
        if (s_resp_val !== 1'b0 || r_resp_val !== 1'b0) begin
            $display("FAIL reset_val: got s=%b r=%b expected 0 0", s_resp_val, r_resp_val);
            tests_failed++;
        end
        tests_run++;
        if (s_resp_data !== mk(0) - mk(0) || r_resp_data !== '0) begin
            $display("FAIL reset_data: got s=%h r=%h expected 0", s_resp_data, r_resp_data);
            tests_failed++;
        end
        tests_run++;
        if (s_rd_rdy !== 1'b1 || r_rd_rdy !== 1'b1) begin
            $display("FAIL reset_rd_rdy: got s=%b r=%b expected 1 1", s_rd_rdy, r_rd_rdy);
            tests_failed++;
        end
        tests_run++;
        if (new_flow_rdy !== 1'b1 || s_wr_rdy !== 1'b1 || r_wr_rdy !== 1'b1) begin
            $display("FAIL reset_wr_rdy: got nf=%b s=%b r=%b expected 1 1 1", new_flow_rdy, s_wr_rdy, r_wr_rdy);
            tests_failed++;
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_new_flow;
        new_flow_val = 1'b1; new_flow_flowid = 6'd5; new_flow_data = mk(50);
        step();
        clr();
        step();
        step();
        s_rd_val = 1'b1; s_rd_fid = 6'd5;
        #1;
        tests_run++;
        if (s_rd_rdy !== 1'b1) begin
            $display("FAIL nf_rd_rdy: got %b expected 1", s_rd_rdy);
            tests_failed++;
        end
        step();
        clr();
        tests_run++;
        if (s_resp_val !== 1'b1 || s_resp_data !== mk(50)) begin
            $display("FAIL nf_read: got val=%b data=%h expected 1 %h", s_resp_val, s_resp_data, mk(50));
            tests_failed++;
        end
        step();
        tests_run++;
        if (s_resp_val !== 1'b0) begin
            $display("FAIL nf_resp_drop: got %b expected 0", s_resp_val);
            tests_failed++;
        end
    endtask

    task automatic test_wr_priority;
        new_flow_val = 1'b1; new_flow_flowid = 6'd3; new_flow_data = mk(30);
        r_wr_val = 1'b1; r_wr_fid = 6'd3; r_wr_data = mk(31);
        #1;
        tests_run++;
        if (r_wr_rdy !== 1'b0 || s_wr_rdy !== 1'b0 || new_flow_rdy !== 1'b1) begin
            $display("FAIL prio_rdy: got nf=%b r=%b s=%b expected 1 0 0", new_flow_rdy, r_wr_rdy, s_wr_rdy);
            tests_failed++;
        end
        step();
        new_flow_val = 1'b0;
        #1;
        tests_run++;
        if (r_wr_rdy !== 1'b1 || s_wr_rdy !== 1'b0) begin
            $display("FAIL prio_rx_only: got r=%b s=%b expected 1 0", r_wr_rdy, s_wr_rdy);
            tests_failed++;
        end
        step();
        clr();
        r_rd_val = 1'b1; r_rd_fid = 6'd3;
        step();
        clr();
        tests_run++;
        if (r_resp_val !== 1'b1 || r_resp_data !== mk(31)) begin
            $display("FAIL prio_read: got val=%b data=%h expected 1 %h", r_resp_val, r_resp_data, mk(31));
            tests_failed++;
        end
        step();
    endtask

    task automatic test_stall;
        s_wr_val = 1'b1; s_wr_fid = 6'd7; s_wr_data = mk(70);
        #1;
        tests_run++;
        if (s_wr_rdy !== 1'b1) begin
            $display("FAIL stall_wr_rdy: got %b expected 1", s_wr_rdy);
            tests_failed++;
        end
        step();
        clr();
        s_rd_val = 1'b1; s_rd_fid = 6'd7; s_resp_rdy = 1'b0;
        step();
        s_rd_val = 1'b0;
        r_wr_val = 1'b1; r_wr_fid = 6'd7; r_wr_data = mk(71);
        for (int k = 0; k < 4; k++) begin
            #1;
            tests_run++;
            if (s_resp_val !== 1'b1 || s_resp_data !== mk(70) || s_rd_rdy !== 1'b0) begin
                $display("FAIL stall_hold%0d: got val=%b data=%h rdy=%b expected 1 %h 0",
                         k, s_resp_val, s_resp_data, s_rd_rdy, mk(70));
                tests_failed++;
            end
            step();
            r_wr_val = 1'b0;
        end
        s_resp_rdy = 1'b1;
        #1;
        tests_run++;
        if (s_rd_rdy !== 1'b1) begin
            $display("FAIL stall_release_rdy: got %b expected 1", s_rd_rdy);
            tests_failed++;
        end
        step();
        tests_run++;
        if (s_resp_val !== 1'b0) begin
            $display("FAIL stall_drain: got %b expected 0", s_resp_val);
            tests_failed++;
        end
        s_rd_val = 1'b1; s_rd_fid = 6'd7;
        step();
        clr();
        tests_run++;
        if (s_resp_data !== mk(71)) begin
            $display("FAIL stall_new_value: got %h expected %h", s_resp_data, mk(71));
            tests_failed++;
        end
        step();
    endtask

    task automatic test_fwd;
        tx_state_struct expv;
`ifdef TX_STATE_STORE_WR_FWD_EN
        expv = mk(91);
`else
        expv = mk(90);
`endif
        new_flow_val = 1'b1; new_flow_flowid = 6'd9; new_flow_data = mk(90);
        step();
        clr();
        s_rd_val = 1'b1; s_rd_fid = 6'd9;
        s_wr_val = 1'b1; s_wr_fid = 6'd9; s_wr_data = mk(91);
        step();
        clr();
        tests_run++;
        if (s_resp_val !== 1'b1 || s_resp_data !== expv) begin
            $display("FAIL fwd_collide: got val=%b data=%h expected 1 %h", s_resp_val, s_resp_data, expv);
            tests_failed++;
        end
        r_rd_val = 1'b1; r_rd_fid = 6'd9;
        step();
        clr();
        tests_run++;
        if (r_resp_data !== mk(91)) begin
            $display("FAIL fwd_after: got %h expected %h", r_resp_data, mk(91));
            tests_failed++;
        end
        step();
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 16; i++) begin
            new_flow_val = 1'b1; new_flow_flowid = 6'(16 + i); new_flow_data = mk(200 + i);
            step();
        end
        clr();
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                s_rd_val = 1'b1; s_rd_fid = 6'(16 + i);
                r_rd_val = 1'b1; r_rd_fid = 6'(31 - i);
                #1;
                tests_run++;
                if (s_rd_rdy !== 1'b1 || r_rd_rdy !== 1'b1) begin
                    $display("FAIL b2b_rdy%0d: got s=%b r=%b expected 1 1", i, s_rd_rdy, r_rd_rdy);
                    tests_failed++;
                end
            end else begin
                clr();
            end
            if (i > 0) begin
                tests_run++;
                if (s_resp_val !== 1'b1 || s_resp_data !== mk(200 + i - 1)) begin
                    $display("FAIL b2b_send%0d: got val=%b data=%h expected 1 %h",
                             i - 1, s_resp_val, s_resp_data, mk(200 + i - 1));
                    tests_failed++;
                end
                tests_run++;
                if (r_resp_val !== 1'b1 || r_resp_data !== mk(215 - (i - 1))) begin
                    $display("FAIL b2b_rx%0d: got val=%b data=%h expected 1 %h",
                             i - 1, r_resp_val, r_resp_data, mk(215 - (i - 1)));
                    tests_failed++;
                end
            end
            step();
        end
        tests_run++;
        if (s_resp_val !== 1'b0 || r_resp_val !== 1'b0) begin
            $display("FAIL b2b_end: got s=%b r=%b expected 0 0", s_resp_val, r_resp_val);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid;
        s_rd_val = 1'b1; s_rd_fid = 6'd5; s_resp_rdy = 1'b0;
        r_rd_val = 1'b1; r_rd_fid = 6'd3; r_resp_rdy = 1'b0;
        step();
        s_rd_val = 1'b0; r_rd_val = 1'b0;
        tests_run++;
        if (s_resp_val !== 1'b1 || r_resp_val !== 1'b1) begin
            $display("FAIL rstmid_pending: got s=%b r=%b expected 1 1", s_resp_val, r_resp_val);
            tests_failed++;
        end
        rst = 1'b1;
        step();
        #1;
        tests_run++;
        if (s_resp_val !== 1'b0 || r_resp_val !== 1'b0 || s_rd_rdy !== 1'b1 || r_rd_rdy !== 1'b1) begin
            $display("FAIL rstmid_drop: got val s=%b r=%b rdy s=%b r=%b expected 0 0 1 1",
                     s_resp_val, r_resp_val, s_rd_rdy, r_rd_rdy);
            tests_failed++;
        end
        rst = 1'b0;
        clr();
        step();
        s_rd_val = 1'b1; s_rd_fid = 6'd5;
        r_rd_val = 1'b1; r_rd_fid = 6'd3;
        step();
        clr();
        tests_run++;
        if (s_resp_data !== mk(50) || r_resp_data !== mk(31)) begin
            $display("FAIL rstmid_retain: got s=%h r=%h expected %h %h", s_resp_data, r_resp_data, mk(50), mk(31));
            tests_failed++;
        end
        step();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        new_flow_flowid = '0; new_flow_data = '0;
        s_rd_fid = '0; s_wr_fid = '0; s_wr_data = '0;
        r_rd_fid = '0; r_wr_fid = '0; r_wr_data = '0;
        clr();
        @(negedge clk);
        test_reset();
        test_new_flow();
        test_wr_priority();
        test_stall();
        test_fwd();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tx_state_store.md
# tx_state_store

Per-flow TCP transmit-state store serving as the responder for the send pipe's `tx_state` read/write interface and the RX pipe's `tx_state` interface. Holds one `tx_state_struct` per flow ID with two independent read ports and one arbitrated write port. Sits beside `send_pipe_wrapper` and the RX pipe in the TCP engine top level.

## Interface
- `DEPTH`, default `2**FLOWID_W`: number of flow entries. `FLOWID_W` and `tx_state_struct` come from `tcp_pkg`.
- `clk` (in, 1): single clock.
- `rst` (in, 1): synchronous, active-high reset.
- `new_flow_val` (in, 1), `new_flow_flowid` (in, FLOWID_W), `new_flow_data` (in, tx_state_struct): initial-state write.
- `new_flow_rdy` (out, 1): always 1, because this port has top write priority.
- `send_pipe_tx_state_rd_req_val` (in, 1), `send_pipe_tx_state_rd_req_flowid` (in, FLOWID_W), `tx_state_send_pipe_rd_req_rdy` (out, 1): send-pipe read request.
- `tx_state_send_pipe_rd_resp_val` (out, 1), `tx_state_send_pipe_rd_resp_data` (out, tx_state_struct), `send_pipe_tx_state_rd_resp_rdy` (in, 1): send-pipe read response.
- `send_pipe_tx_state_wr_req_val` (in, 1), `send_pipe_tx_state_wr_req_flowid` (in, FLOWID_W), `send_pipe_tx_state_wr_req_data` (in, tx_state_struct), `tx_state_send_pipe_wr_req_rdy` (out, 1): send-pipe write.
- `rx_pipe_tx_state_rd_req_val`, `rx_pipe_tx_state_rd_req_flowid`, `tx_state_rx_pipe_rd_req_rdy`: RX-pipe read request. Same widths as the send-pipe read request.
- `tx_state_rx_pipe_rd_resp_val`, `tx_state_rx_pipe_rd_resp_data`, `rx_pipe_tx_state_rd_resp_rdy`: RX-pipe read response.
- `rx_pipe_tx_state_wr_req_val`, `rx_pipe_tx_state_wr_req_flowid`, `rx_pipe_tx_state_wr_req_data`, `tx_state_rx_pipe_wr_req_rdy`: RX-pipe write.

## Operation
- Storage is a DEPTH-entry array of tx_state_struct with two synchronous read ports and one write port.
- Array contents are not reset; an entry is undefined until it has been written.
- Write arbitration is fixed priority: new_flow > rx_pipe > send_pipe.
  - `tx_state_rx_pipe_wr_req_rdy = !new_flow_val`.
  - `tx_state_send_pipe_wr_req_rdy = !new_flow_val && !rx_pipe_tx_state_wr_req_val`.
  - A write commits at the clock edge of the cycle in which val && rdy.
- Each read port runs independently with a one-entry response register:
  - rd_req_rdy = !resp_val || resp_rdy, so back-to-back reads flow at full rate when the consumer is ready.
  - When a request is accepted in cycle N, the response is valid in cycle N+1.
  - The response data and val are held stable until resp_rdy is sampled high.
- The response reflects array state at the accept edge. Writes committed after acceptance never alter a pending response.
- Same-cycle read accept and committed write to the same flowid are resolved by the configuration macro (see Configuration).
- Writes from losing requesters are not dropped; the requester must hold val until rdy.

## Timing
- Reset values: both rd_resp_val = 0, both rd_resp_data = 0.
- Reset value of rd_req_rdy: 1 for both read ports.
- Write-port rdy outputs are combinational from the other write vals; they are 1 during reset if no higher-priority val is asserted.
- Read latency is 1 cycle. Throughput is 1 read per port per cycle, plus 1 write per cycle.
- Reset mid-operation: pending responses are discarded (val goes to 0 the next cycle). Array contents are retained.
- Simultaneous writes to the same flowid: only the highest-priority write commits.
- rd_req_rdy depends combinationally on resp_rdy. This is the only combinational path from input to output besides the write arbitration.

## Configuration
- `TX_STATE_STORE_WR_FWD_EN`:
  - Defined: a read accepted in the same cycle as a committed write to the same flowid returns the written data (write-first forwarding, applied per read port).
  - Undefined: such a read returns the pre-write array value (read-first).
  - All other behaviour is identical in both builds.

## Test plan
- Write new_flow flowid 5 with data A, then send-pipe read flowid 5 two cycles later -> resp_val high one cycle after accept with data A.
- Same cycle: new_flow_val to flowid 3 (data B) and rx-pipe write to flowid 3 (data C) -> rx rdy = 0; C commits one cycle later. A read afterwards returns C.
- Send-pipe read flowid 7 with resp_rdy held 0 for 4 cycles, while the rx pipe writes flowid 7 = D in that window -> response stays at the old value, stable, and req_rdy = 0 until resp_rdy rises.
- Same cycle: send-pipe read flowid 9 plus send-pipe write flowid 9 = E (old value F) -> response E with `TX_STATE_STORE_WR_FWD_EN` defined, F without it.
- Both read ports issue 16 back-to-back reads with resp_rdy = 1 -> 16 responses in 16 consecutive cycles, in order, with no bubbles.
- Assert rst while both responses are valid and stalled -> both resp_val drop to 0 the next cycle and req_rdy = 1. A later read of a previously written flow returns its pre-reset data.
